up_counter_ctrl: RTL and testbench

UP_COUNTER_CTRL -- requirements
Module: up_counter_ctrl

---
 rtl/up_counter_ctrl.sv | 95 +++++++++
 tb/tb_up_counter_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/up_counter_ctrl.sv
// Up-counter with IDLE/RUN/DONE control, parallel load, programmable limit
// and a one-cycle terminal-count pulse (wrap or one-shot stop at limit).
module up_counter_ctrl #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   input  logic             one_shot,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             running,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;

   // Next state: stop > load > start > terminal check > increment
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tc_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (stop) begin
               state_d = IDLE;
            end else if (load) begin
               count_d = load_val;
            end else if (start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (load) begin
               count_d = load_val;
            end else if (count_q == limit) begin
               tc_d = 1'b1;
               if (one_shot) begin
                  state_d = DONE;
               end else begin
                  count_d = '0;
               end
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end
         DONE: begin
            if (stop) begin
               state_d = IDLE;
            end else if (load) begin
               count_d = load_val;
               state_d = IDLE;
            end else if (start) begin
               count_d = '0;
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   assign count   = count_q;
   assign tc      = tc_q;
   assign running = (state_q == RUN);
   assign done    = (state_q == DONE);

endmodule

// File: tb/tb_up_counter_ctrl.sv
// Directed-vector bench for up_counter_ctrl: the driver queues the expected
// post-edge outputs, a negedge monitor pops and compares them.
module tb_up_counter_ctrl;

   logic       clk;
   logic       reset, start, stop, load, one_shot;
   logic [3:0] load_val, limit;
   logic [3:0] count;
   logic       tc, running, done;

   up_counter_ctrl #(.WIDTH(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .stop     (stop),
      .load     (load),
      .load_val (load_val),
      .limit    (limit),
      .one_shot (one_shot),
      .count    (count),
      .tc       (tc),
      .running  (running),
      .done     (done)
   );

   typedef struct {
      logic       rst, st, sp, ld;
      logic [3:0] lv, lim;
      logic       os;
      logic [3:0] ec;
      logic       etc, er, ed;
   } vec_t;

   typedef struct {
      int         idx;
      logic [3:0] c;
      logic       tc, r, d;
   } exp_t;

   vec_t       vq[$];
   exp_t       sb[$];
   exp_t       e;
   logic [3:0] cur_lim;
   logic       cur_os;
   int         n_cmp = 0;
   int         n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Append one vector: inputs for an edge and the outputs expected after it
   task automatic add(input logic rst, input logic st, input logic sp, input logic ld,
                      input logic [3:0] lv, input logic [3:0] ec, input logic etc,
                      input logic er, input logic ed);
      vec_t v;
      v.rst = rst; v.st = st; v.sp = sp; v.ld = ld; v.lv = lv;
      v.lim = cur_lim; v.os = cur_os;
      v.ec = ec; v.etc = etc; v.er = er; v.ed = ed;
      vq.push_back(v);
   endtask

   // Plain RUN cycles expecting count first..last, no tc
   task automatic run_seq(input int first, input int last);
      for (int i = first; i <= last; i++) add(0, 0, 0, 0, 4'd0, 4'(i), 0, 1, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0;
      load_val = '0; limit = 4'd9; one_shot = 1'b0;

      // Reset, then free-running wrap at limit 9
      cur_lim = 4'd9; cur_os = 1'b0;
      add(1, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
      add(1, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
      add(0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
      add(0, 1, 0, 0, 4'd0, 4'd0, 0, 1, 0);
      run_seq(1, 9);
      add(0, 0, 0, 0, 4'd0, 4'd0, 1, 1, 0);
      run_seq(1, 3);
      // Load above limit: natural wrap without tc, then tc at 9
      add(0, 0, 0, 1, 4'd12, 4'd12, 0, 1, 0);
      run_seq(13, 15);
      run_seq(0, 9);
      add(0, 0, 0, 0, 4'd0, 4'd0, 1, 1, 0);
      run_seq(1, 9);
      // stop and load together at count==limit
      add(0, 0, 1, 1, 4'd3, 4'd9, 0, 0, 0);
      add(0, 0, 0, 1, 4'd7, 4'd7, 0, 0, 0);
      add(0, 1, 0, 0, 4'd0, 4'd7, 0, 1, 0);
      // Reset mid-RUN
      add(1, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
      add(0, 1, 0, 0, 4'd0, 4'd0, 0, 1, 0);
      run_seq(1, 1);
      add(0, 1, 0, 0, 4'd0, 4'd2, 0, 1, 0);
      add(0, 0, 1, 0, 4'd0, 4'd2, 0, 0, 0);
      // One-shot to limit 5
      cur_lim = 4'd5; cur_os = 1'b1;
      add(0, 0, 0, 1, 4'd0, 4'd0, 0, 0, 0);
      add(0, 1, 0, 0, 4'd0, 4'd0, 0, 1, 0);
      run_seq(1, 5);
      add(0, 0, 0, 0, 4'd0, 4'd5, 1, 0, 1);
      add(0, 0, 0, 0, 4'd0, 4'd5, 0, 0, 1);
      add(0, 1, 0, 0, 4'd0, 4'd0, 0, 1, 0);
      run_seq(1, 1);
      cur_lim = 4'd1;
      add(0, 0, 0, 0, 4'd0, 4'd1, 1, 0, 1);
      add(0, 0, 0, 1, 4'd4, 4'd4, 0, 0, 0);
      // limit 0, wrapping: tc every RUN cycle
      cur_lim = 4'd0; cur_os = 1'b0;
      add(0, 0, 0, 1, 4'd0, 4'd0, 0, 0, 0);
      add(0, 1, 0, 0, 4'd0, 4'd0, 0, 1, 0);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 4'd0, 4'd0, 1, 1, 0);
      add(0, 0, 1, 0, 4'd0, 4'd0, 0, 0, 0);
      add(0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
      // limit 0, one-shot: single tc then DONE
      cur_os = 1'b1;
      add(0, 1, 0, 0, 4'd0, 4'd0, 0, 1, 0);
      add(0, 0, 0, 0, 4'd0, 4'd0, 1, 0, 1);
      add(0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 1);
      // Reset from DONE, reset beats start
      add(1, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
      add(0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
      add(1, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0);

      for (int i = 0; i < vq.size(); i++) begin
         exp_t x;
         @(negedge clk);
         reset = vq[i].rst; start = vq[i].st; stop = vq[i].sp; load = vq[i].ld;
         load_val = vq[i].lv; limit = vq[i].lim; one_shot = vq[i].os;
         @(posedge clk);
         #1;
         x.idx = i; x.c = vq[i].ec; x.tc = vq[i].etc; x.r = vq[i].er; x.d = vq[i].ed;
         sb.push_back(x);
      end
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expected entries left, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Monitor: compare DUT outputs against the oldest queued expectation
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if ({count, tc, running, done} !== {e.c, e.tc, e.r, e.d}) begin
               n_bad++;
               $display("FAIL step%0d: got count=%0d tc=%b running=%b done=%b, required count=%0d tc=%b running=%b done=%b",
                        e.idx, count, tc, running, done, e.c, e.tc, e.r, e.d);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish within 100000 time units");
      $fatal(1);
   end

endmodule
